// File: rtl/fifo_wr_arbiter_pkg.sv
// rtl/fifo_wr_arbiter_pkg.sv - shared types for the FIFO write-port arbiter
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - source beats in, FIFO write side out
interface fifo_wr_arbiter_if #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 36
);
    localparam int SRC_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0]            src_valid;
    logic [NUM_SRC-1:0]            src_last;
    logic [NUM_SRC*DATA_WIDTH-1:0] src_data;
    logic [NUM_SRC-1:0]            src_ready;
    logic                          full;
    logic                          wr_en;
    logic [DATA_WIDTH-1:0]         wr_data;
    logic [SRC_W-1:0]              grant_id;
    logic                          busy;

    modport master (
        output src_valid, src_last, src_data, full,
        input  src_ready, wr_en, wr_data, grant_id, busy
    );

    modport slave (
        input  src_valid, src_last, src_data, full,
        output src_ready, wr_en, wr_data, grant_id, busy
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - rotate-priority picker, scan starts just after ptr
module fifo_rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] gnt_onehot,
    output logic [SRC_W-1:0]   gnt_idx,
    output logic               any
);

    logic [SRC_W-1:0] idx;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        idx        = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = SRC_W'((int'(ptr) + k) % NUM_SRC);
            if (!any && req[idx]) begin
                any             = 1'b1;
                gnt_idx         = idx;
                gnt_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin, packet-atomic sharing of one FIFO write port
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 36,
    parameter int PKT_MODE   = 1
) (
    input logic               clk,
    input logic               rst,
    fifo_wr_arbiter_if.slave  bus
);

    localparam int SRC_W = $clog2(NUM_SRC);

    arb_state_e       state_q, state_d;
    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0] owner_q, owner_d;
    logic [SRC_W-1:0] grant_id_q, grant_id_d;

    logic [NUM_SRC-1:0] pick_onehot, owner_onehot, sel_onehot;
    logic [SRC_W-1:0]   pick_idx, sel;
    logic               pick_any, open, accept, sel_last;

    fifo_rr_pick #(.NUM_SRC(NUM_SRC), .SRC_W(SRC_W)) u_pick (
        .req        (bus.src_valid),
        .ptr        (rr_ptr_q),
        .gnt_onehot (pick_onehot),
        .gnt_idx    (pick_idx),
        .any        (pick_any)
    );

    always_comb begin
        owner_onehot          = '0;
        owner_onehot[owner_q] = 1'b1;
        if (state_q == ST_BUSY) begin
            sel        = owner_q;
            sel_onehot = owner_onehot;
        end else begin
            sel        = pick_idx;
            sel_onehot = pick_onehot;
        end
        // Gating with rst keeps the FIFO untouched while reset is held.
        open     = ~rst & ~bus.full;
        accept   = open & ((state_q == ST_BUSY) ? bus.src_valid[owner_q] : pick_any);
        sel_last = bus.src_last[sel];

        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        grant_id_d = grant_id_q;
        if (accept) begin
            if (state_q == ST_IDLE) begin
                rr_ptr_d   = sel;
                owner_d    = sel;
                grant_id_d = sel;
                if (PKT_MODE != 0 && !sel_last) begin
                    state_d = ST_BUSY;
                end
            end else if (sel_last) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= SRC_W'(NUM_SRC - 1);
            owner_q    <= '0;
            grant_id_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            grant_id_q <= grant_id_d;
        end
    end

    assign bus.src_ready = sel_onehot & {NUM_SRC{open}};
    assign bus.wr_en     = accept;
    assign bus.wr_data   = bus.src_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
    assign bus.grant_id  = grant_id_q;
    assign bus.busy      = (state_q == ST_BUSY);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 36;
    localparam int SW = 2;

    typedef logic [DW:0] beat_t;
    typedef struct {
        string          name;
        int             kind;
        logic [3:0]     mask;
        logic           busy;
        logic [SW-1:0]  gid;
        logic           wr;
        logic [N-1:0]   rdy;
        int             val;
    } st_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_SRC(N), .DATA_WIDTH(DW)) bus ();

    fifo_wr_arbiter #(.NUM_SRC(N), .DATA_WIDTH(DW), .PKT_MODE(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    beat_t         src_q[N][$];
    logic [DW-1:0] src_exp[N][$];
    logic [DW-1:0] exp_q[$];
    st_t           st_q[$];
    logic          rand_mode = 1'b0;
    logic          rand_gap  = 1'b0;
    logic [N-1:0]  xfer = '0;
    int            n_tests = 0;
    int            n_fail  = 0;

    function automatic logic [DW-1:0] mk(int s, int p, int b);
        return {4'(s), 16'(p), 16'(b)};
    endfunction

    function automatic int beats_left();
        int t = 0;
        for (int i = 0; i < N; i++) t += src_q[i].size();
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(int s, int p, int n);
        for (int b = 0; b < n; b++) begin
            src_q[s].push_back({(b == n - 1), mk(s, p, b)});
            src_exp[s].push_back(mk(s, p, b));
        end
    endtask

    task automatic expw(int s, int p, int n);
        for (int b = 0; b < n; b++) exp_q.push_back(mk(s, p, b));
    endtask

    task automatic push_st(string name, logic [3:0] m, logic bsy, int gid, logic wr, logic [N-1:0] rdy);
        st_t t;
        t.name = name; t.kind = 0; t.mask = m; t.busy = bsy;
        t.gid = SW'(gid); t.wr = wr; t.rdy = rdy; t.val = 0;
        st_q.push_back(t);
    endtask

    task automatic push_kind(string name, int kind, int val);
        st_t t;
        t.name = name; t.kind = kind; t.mask = '0; t.busy = 1'b0;
        t.gid = '0; t.wr = 1'b0; t.rdy = '0; t.val = val;
        st_q.push_back(t);
    endtask

    task automatic drain(string name);
        int k = 0;
        while (beats_left() != 0 && k < 1000) begin
            tick();
            k++;
        end
        tick();
        tick();
        push_kind(name, 1, beats_left());
        tick();
    endtask

    task automatic do_reset(string name);
        rst = 1'b1;
        push_st(name, 4'b1111, 1'b0, 0, 1'b0, 4'b0000);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Source models: present queue heads, retire beats that transferred last cycle.
    initial begin
        logic [N-1:0]    v, l;
        logic [N*DW-1:0] d;
        beat_t           b;
        bus.src_valid = '0;
        bus.src_last  = '0;
        bus.src_data  = '0;
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < N; i++)
                if (xfer[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            v = '0; l = '0; d = '0;
            for (int i = 0; i < N; i++) begin
                if (src_q[i].size() > 0) begin
                    b = src_q[i][0];
                    d[i*DW +: DW] = b[DW-1:0];
                    if (!(rand_gap && $urandom_range(3) == 0)) begin
                        v[i] = 1'b1;
                        l[i] = b[DW];
                    end
                end
            end
            bus.src_valid = v;
            bus.src_last  = l;
            bus.src_data  = d;
        end
    end

    // Monitor: every write is checked against the scoreboard; status items are checked in order.
    always @(negedge clk) begin
        logic [DW-1:0] got, want;
        int            s, left;
        logic          open_pkt;
        int            open_src;
        st_t           t;
        xfer = bus.src_valid & bus.src_ready;
        if (bus.wr_en) begin
            got = bus.wr_data;
            s   = int'(got[DW-1:DW-4]);
            chk("wr_while_full_or_rst", 64'(bus.full | rst), 64'(0));
            if (!rand_mode) begin
                chk("wr_unexpected", 64'(exp_q.size() == 0), 64'(0));
                if (exp_q.size() > 0) begin
                    want = exp_q.pop_front();
                    chk("wr_data", 64'(got), 64'(want));
                end
            end else begin
                chk("rnd_src_range", 64'(s >= N), 64'(0));
                if (s < N) begin
                    chk("rnd_unexpected", 64'(src_exp[s].size() == 0), 64'(0));
                    if (src_exp[s].size() > 0) begin
                        want = src_exp[s].pop_front();
                        chk("rnd_order", 64'(got), 64'(want));
                    end
                    if (open_pkt) chk("rnd_contiguous", 64'(s), 64'(open_src));
                    open_pkt = !bus.src_last[s[SW-1:0]];
                    open_src = s;
                end
            end
        end
        if (st_q.size() > 0) begin
            t = st_q.pop_front();
            if (t.kind == 0) begin
                if (t.mask[0]) chk({t.name, "_busy"}, 64'(bus.busy), 64'(t.busy));
                if (t.mask[1]) chk({t.name, "_gid"}, 64'(bus.grant_id), 64'(t.gid));
                if (t.mask[2]) chk({t.name, "_wr_en"}, 64'(bus.wr_en), 64'(t.wr));
                if (t.mask[3]) chk({t.name, "_ready"}, 64'(bus.src_ready), 64'(t.rdy));
            end else if (t.kind == 1) begin
                chk({t.name, "_src_drained"}, 64'(t.val), 64'(0));
                left = exp_q.size();
                if (rand_mode)
                    for (int i = 0; i < N; i++) left += src_exp[i].size();
                chk({t.name, "_writes_missing"}, 64'(left), 64'(0));
            end else begin
                $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
                $finish;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int pid;
        rst      = 1'b1;
        bus.full = 1'b0;

        // 1: single-beat packet from src0 right after reset
        do_reset("t0_reset");
        send(0, 1, 1); expw(0, 1, 1);
        push_st("t1_same_cycle", 4'b1101, 1'b0, 0, 1'b1, 4'b0001);
        tick();
        push_st("t1_after", 4'b0111, 1'b0, 0, 1'b0, 4'b0000);
        drain("t1");

        // 2: fairness with all sources holding single-beat packets
        do_reset("t2_reset");
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < N; s++) begin
                send(s, 10 + p, 1);
                expw(s, 10 + p, 1);
            end
        for (int c = 0; c < 8; c++) begin
            push_st($sformatf("t2_c%0d", c), 4'b1111, 1'b0, (c == 0) ? 0 : (c - 1) % N,
                    1'b1, N'(1 << (c % N)));
            tick();
        end
        push_st("t2_idle", 4'b0111, 1'b0, 3, 1'b0, 4'b0000);
        drain("t2");

        // 3: src1 3-beat packet holds the port against src0/src2
        do_reset("t3_reset");
        send(0, 20, 1); expw(0, 20, 1);
        drain("t3_pre");
        send(1, 21, 3); send(0, 22, 1); send(2, 23, 1);
        expw(1, 21, 3); expw(2, 23, 1); expw(0, 22, 1);
        push_st("t3_c0", 4'b1101, 1'b0, 0, 1'b1, 4'b0010); tick();
        push_st("t3_c1", 4'b1111, 1'b1, 1, 1'b1, 4'b0010); tick();
        push_st("t3_c2", 4'b1111, 1'b1, 1, 1'b1, 4'b0010); tick();
        push_st("t3_c3", 4'b1111, 1'b0, 1, 1'b1, 4'b0100); tick();
        push_st("t3_c4", 4'b1111, 1'b0, 2, 1'b1, 4'b0001);
        drain("t3");

        // 4: full raised mid-packet for 5 cycles, src3 waiting
        send(2, 30, 4); expw(2, 30, 4); expw(3, 31, 1);
        push_st("t4_c0", 4'b1101, 1'b0, 0, 1'b1, 4'b0100); tick();
        bus.full = 1'b1;
        send(3, 31, 1);
        for (int c = 0; c < 5; c++) begin
            push_st($sformatf("t4_full%0d", c), 4'b1111, 1'b1, 2, 1'b0, 4'b0000);
            tick();
        end
        bus.full = 1'b0;
        push_st("t4_resume", 4'b1111, 1'b1, 2, 1'b1, 4'b0100);
        drain("t4");

        // 5: reset while src3 owns the port; src3 resends afterwards
        send(3, 40, 3);
        exp_q.push_back(mk(3, 40, 0)); exp_q.push_back(mk(3, 40, 1));
        expw(0, 41, 1); expw(3, 40, 3);
        push_st("t5_c0", 4'b1101, 1'b0, 0, 1'b1, 4'b1000); tick();
        push_st("t5_c1", 4'b1111, 1'b1, 3, 1'b1, 4'b1000);
        @(posedge clk);
        #3;
        rst = 1'b1;
        src_q[3].delete();
        send(3, 40, 3); send(0, 41, 1);
        push_st("t5_in_rst", 4'b1111, 1'b0, 0, 1'b0, 4'b0000);
        tick();
        rst = 1'b0;
        push_st("t5_d0", 4'b1111, 1'b0, 0, 1'b1, 4'b0001); tick();
        push_st("t5_d1", 4'b1111, 1'b0, 0, 1'b1, 4'b1000); tick();
        push_st("t5_d2", 4'b1111, 1'b1, 3, 1'b1, 4'b1000); tick();
        push_st("t5_d3", 4'b1111, 1'b1, 3, 1'b1, 4'b1000);
        drain("t5");

        // 6: random packets, random full, random source bubbles
        for (int i = 0; i < N; i++) src_exp[i].delete();
        rand_mode = 1'b1;
        rand_gap  = 1'b1;
        pid = 100;
        for (int c = 0; c < 10000; c++) begin
            bus.full = ($urandom_range(9) < 3);
            for (int s = 0; s < N; s++)
                if (src_q[s].size() < 6 && $urandom_range(7) == 0) begin
                    send(s, pid, int'($urandom_range(4, 1)));
                    pid++;
                end
            tick();
        end
        bus.full = 1'b0;
        drain("t6");
        push_kind("end", 3, 0);
        forever tick();
    end

endmodule
